// File: rtl/stream_disp_gearbox_pkg.sv
// stream_disp_gearbox_pkg
// Sizing helpers shared by the stream_disp_gearbox width converter.
//   max_int    : larger of two integers
//   buf_coef   : re-pack buffer depth in coefficients, 2*max(in, out)
//   occ_width  : bits needed for an occupancy count of 0..buf_coef
package stream_disp_gearbox_pkg;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int buf_coef(input int in_c, input int out_c);
      return 2 * max_int(in_c, out_c);
   endfunction

   function automatic int occ_width(input int in_c, input int out_c);
      return $clog2(buf_coef(in_c, out_c) + 1);
   endfunction

endpackage

// File: rtl/stream_disp_gearbox_fifo_element.sv
// fifo_element
// Two-entry registered valid/ready FIFO. Both ready and valid come from
// registers, so it breaks every combinational path between its two sides
// while still sustaining one transfer per cycle.
// Ports:
//   clk, s_rst_n        clock, synchronous active-low reset
//   in_data/in_vld/in_rdy     write side
//   out_data/out_vld/out_rdy  read side
module fifo_element #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             s_rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic [WIDTH-1:0] out_data,
   output logic             out_vld,
   input  logic             out_rdy
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_cnt;
   logic             w_push;
   logic             w_pop;

   assign in_rdy   = (r_cnt != 2'd2);
   assign out_vld  = (r_cnt != 2'd0);
   assign out_data = r_mem[r_rd_ptr];
   assign w_push   = in_vld & in_rdy;
   assign w_pop    = out_vld & out_rdy;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/stream_disp_gearbox.sv
// stream_disp_gearbox
// Re-packs a stream of IN_COEF-coefficient words into OUT_COEF-coefficient
// words for any ratio. Coefficients flow through a shift buffer: pops take
// the bottom OUT_COEF entries and shift down, pushes land just above the
// post-shift occupancy, so stream order is preserved exactly.
// Build option STREAM_DISP_GEARBOX_LAST_EN: honour in_last, flushing the
// trailing partial word with out_last and a partial out_keep. Without it
// in_last is ignored, out_last is 0 and out_keep is all ones.
// Ports:
//   clk, s_rst_n                         clock, synchronous active-low reset
//   in_data/in_last/in_vld/in_rdy        input stream (coef 0 first)
//   out_data/out_keep/out_last/out_vld/out_rdy  output stream
// OUT_PIPE=1 adds a 2-deep fifo_element on the output.
module stream_disp_gearbox
   import stream_disp_gearbox_pkg::*;
#(
   parameter int OP_W     = 32,
   parameter int IN_COEF  = 8,
   parameter int OUT_COEF = 6,
   parameter bit OUT_PIPE = 1'b1
) (
   input  logic                              clk,
   input  logic                              s_rst_n,
   input  logic [IN_COEF-1:0][OP_W-1:0]      in_data,
   input  logic                              in_last,
   input  logic                              in_vld,
   output logic                              in_rdy,
   output logic [OUT_COEF-1:0][OP_W-1:0]     out_data,
   output logic [OUT_COEF-1:0]               out_keep,
   output logic                              out_last,
   output logic                              out_vld,
   input  logic                              out_rdy
);

   localparam int BUF_COEF = buf_coef(IN_COEF, OUT_COEF);
   localparam int OCC_W    = occ_width(IN_COEF, OUT_COEF);
   localparam int IDX_W    = $clog2(BUF_COEF);
   localparam int PKT_W    = OUT_COEF * OP_W + OUT_COEF + 1;
   localparam logic [OCC_W-1:0] C_IN   = OCC_W'(IN_COEF);
   localparam logic [OCC_W-1:0] C_OUT  = OCC_W'(OUT_COEF);
   localparam logic [OCC_W-1:0] C_ROOM = OCC_W'(BUF_COEF - IN_COEF);

   logic [BUF_COEF-1:0][OP_W-1:0] r_buf;
   logic [BUF_COEF-1:0][OP_W-1:0] w_buf_next;
   logic [OCC_W-1:0]              r_occ;
   logic [OCC_W-1:0]              w_occ_next;
   logic [OCC_W-1:0]              w_popped;
   logic [OCC_W-1:0]              w_base;
   logic [IDX_W-1:0]              w_wr_idx;
   logic                          w_flush;
   logic                          w_push;
   logic                          w_pop;
   logic                          w_s1_vld;
   logic                          w_s1_rdy;
   logic                          w_s1_last;
   logic [OUT_COEF-1:0]           w_s1_keep;
   logic [OUT_COEF-1:0][OP_W-1:0] w_s1_data;

`ifdef STREAM_DISP_GEARBOX_LAST_EN
   logic r_flush;
   logic w_flush_next;
   assign w_flush   = r_flush;
   // The pop that empties the buffer during a flush closes the packet.
   assign w_s1_last = r_flush & (r_occ <= C_OUT);
`else
   logic w_unused_last;
   assign w_unused_last = in_last;
   assign w_flush       = 1'b0;
   assign w_s1_last     = 1'b0;
`endif

   assign w_s1_vld = (r_occ >= C_OUT) | (w_flush & (r_occ != '0));
   assign w_pop    = w_s1_vld & w_s1_rdy;
   assign w_popped = w_pop ? ((r_occ < C_OUT) ? r_occ : C_OUT) : '0;
   // Registered-only ready: room is judged before this cycle's pop.
   assign in_rdy   = (r_occ <= C_ROOM) & ~w_flush;
   assign w_push   = in_vld & in_rdy;

   always_comb begin
      w_buf_next = r_buf;
      w_wr_idx   = '0;
      w_base     = r_occ - w_popped;
      if (w_pop) begin
         for (int i = 0; i < BUF_COEF - OUT_COEF; i++) w_buf_next[i] = r_buf[i + OUT_COEF];
         for (int i = BUF_COEF - OUT_COEF; i < BUF_COEF; i++) w_buf_next[i] = '0;
      end
      if (w_push) begin
         for (int j = 0; j < IN_COEF; j++) begin
            w_wr_idx             = IDX_W'(w_base + OCC_W'(j));
            w_buf_next[w_wr_idx] = in_data[j];
         end
      end
      w_occ_next = r_occ + (w_push ? C_IN : '0) - w_popped;
`ifdef STREAM_DISP_GEARBOX_LAST_EN
      w_flush_next = r_flush;
      if (w_push & in_last)        w_flush_next = 1'b1;
      else if (w_pop & w_s1_last)  w_flush_next = 1'b0;
`endif
      // Coefficients beyond the occupancy of a closing pop are padded with zero.
      w_s1_keep = '1;
      w_s1_data = '0;
      for (int i = 0; i < OUT_COEF; i++) begin
         w_s1_keep[i] = ~w_s1_last | (OCC_W'(i) < r_occ);
         w_s1_data[i] = w_s1_keep[i] ? r_buf[i] : '0;
      end
   end

   always_ff @(posedge clk) begin
      r_buf <= w_buf_next;
      if (!s_rst_n) begin
         r_occ   <= '0;
`ifdef STREAM_DISP_GEARBOX_LAST_EN
         r_flush <= 1'b0;
`endif
      end else begin
         r_occ   <= w_occ_next;
`ifdef STREAM_DISP_GEARBOX_LAST_EN
         r_flush <= w_flush_next;
`endif
         assert (!w_pop || (r_occ != '0))
            else $error("stream_disp_gearbox: pop from empty buffer");
         assert ((int'(r_occ) + (w_push ? IN_COEF : 0) - int'(w_popped)) <= BUF_COEF)
            else $error("stream_disp_gearbox: buffer overflow");
      end
   end

   generate
      if (OUT_PIPE) begin : g_pipe
         logic [PKT_W-1:0] w_pkt_in;
         logic [PKT_W-1:0] w_pkt_out;
         logic             w_fifo_vld;

         assign w_pkt_in = {w_s1_last, w_s1_keep, w_s1_data};

         fifo_element #(.WIDTH(PKT_W)) u_fifo (
            .clk      (clk),
            .s_rst_n  (s_rst_n),
            .in_data  (w_pkt_in),
            .in_vld   (w_s1_vld),
            .in_rdy   (w_s1_rdy),
            .out_data (w_pkt_out),
            .out_vld  (w_fifo_vld),
            .out_rdy  (out_rdy)
         );

         // FIFO storage is not reset; present idle sideband values while empty.
         assign out_vld  = w_fifo_vld;
         assign out_data = w_pkt_out[OUT_COEF*OP_W-1:0];
         assign out_keep = w_fifo_vld ? w_pkt_out[OUT_COEF*OP_W +: OUT_COEF] : '1;
         assign out_last = w_fifo_vld & w_pkt_out[PKT_W-1];
      end else begin : g_direct
         assign w_s1_rdy = out_rdy;
         assign out_vld  = w_s1_vld;
         assign out_data = w_s1_data;
         assign out_keep = w_s1_keep;
         assign out_last = w_s1_last & w_s1_vld;
      end
   endgenerate

endmodule

// File: doc/stream_disp_gearbox.md
# stream_disp_gearbox

Generalised stream width converter for the stream_dispatch path. It re-packs a stream of IN_COEF-coefficient words into OUT_COEF-coefficient words for any ratio, integer or not (e.g. 3→2, 2→3, 5→8). It can flush a trailing partial word on an end-of-packet marker. It sits between a stream producer and stream_dispatch consumers whose bus widths are not multiples of each other.

## Interface
Parameters:
- OP_W, 32, coefficient width in bits.
- IN_COEF, 8, coefficients per input word (≥1).
- OUT_COEF, 6, coefficients per output word (≥1); no divisibility constraint.
- OUT_PIPE, 1'b1, adds a 2-deep fifo_element (TYPE_ARRAY 8'h12) on the output.

Ports:
- clk  in  1  clock.
- s_rst_n  in  1  reset: synchronous, active-low; clock clk.
- in_data  in  [IN_COEF-1:0][OP_W-1:0]  input word, coefficient 0 first in stream order.
- in_last  in  1  final word of packet (used only with STREAM_DISP_GEARBOX_LAST_EN).
- in_vld  in  1  input valid.
- in_rdy  out  1  input ready.
- out_data  out  [OUT_COEF-1:0][OP_W-1:0]  output word.
- out_keep  out  OUT_COEF  per-coefficient valid mask.
- out_last  out  1  final word of packet.
- out_vld  out  1  output valid.
- out_rdy  in  1  output ready.

## Operation
- Buffer: BUF_COEF = 2*max(IN_COEF, OUT_COEF) coefficients. Occupancy counter occ is $clog2(BUF_COEF+1) bits wide.
- Pop (core side): s1_vld = (occ ≥ OUT_COEF) | (flush & occ ≠ 0). A pop occurs when s1_vld & s1_rdy.
  - A pop presents buf[0..OUT_COEF-1], shifts the buffer down by OUT_COEF and subtracts min(occ, OUT_COEF) from occ.
- Push: in_rdy = (occ ≤ BUF_COEF-IN_COEF) & ~flush. in_rdy is derived from registers only; there is no combinational path from out_rdy.
  - A push writes in_data at index occ-popped (i.e. after this cycle's shift) and adds IN_COEF to occ.
- Push and pop in the same cycle are both applied, so occ_next = occ + IN_COEF - popped.
- Stream order is preserved exactly: coefficient k of the input stream is coefficient k of the output stream.
- Flush (LAST_EN only):
  - Accepting a word with in_last=1 sets flush. in_rdy is held at 0 while flush is set.
  - Pops then proceed, including a final partial word.
  - On the pop where occ ≤ OUT_COEF: out_last=1; out_keep[i]=1 for i<occ, 0 otherwise; padded coefficients are zero. flush clears on that pop.
  - If in_last arrives and occ+IN_COEF is an exact multiple of OUT_COEF, no partial word is produced; the last full word carries out_last=1 with out_keep all ones.
- Non-last pops: out_keep all ones, out_last=0.
- Underflow and overflow are impossible by construction. Both are checked by assertion.

## Timing
- Reset: occ=0, flush=0, in_rdy=1, s1_vld=0, out_vld=0, out_last=0, out_keep='1. Buffer data is not reset.
- Reset mid-packet discards all buffered coefficients. No output follows until new input arrives.
- Latency, in_vld to out_vld:
  - 1 cycle when OUT_PIPE=0 (buffer is registered).
  - 2 cycles when OUT_PIPE=1 (fifo_element adds one registered stage).
  - Both figures assume the accepted word brings occ ≥ OUT_COEF or sets flush.
- Throughput: with out_rdy held high, the narrower side runs every cycle. Sustained rate is min(IN_COEF, OUT_COEF) coefficients per cycle, with no bubbles once occ has primed.
- Valid/ready: out_vld is not withdrawn and out_data, out_keep and out_last stay stable until accepted. in_vld is not required to stay asserted.

## Configuration
- STREAM_DISP_GEARBOX_LAST_EN defined: in_last is honoured, with the flush, out_last and out_keep behaviour described above.
- STREAM_DISP_GEARBOX_LAST_EN undefined: in_last is ignored and the flush register is removed. out_last ties to 0 and out_keep ties to all ones. A trailing partial word stays in the buffer until later input completes it.

## Structure
- stream_disp_gearbox_pkg: function max_int, function buf_coef(in, out), and typedef-free localparam helpers for occupancy width.
- No sub-module beyond the existing fifo_element for OUT_PIPE. The buffer, occupancy counter and flush logic stay in one always_ff/always_comb pair.

## Test plan
- IN=3, OUT=2, out_rdy=1, 4 words holding coefficients 0..11 → 6 outputs {0,1},{2,3}…{10,11}; in_rdy drops only when occ>3.
- IN=2, OUT=3, continuous input of 0..11 → outputs {0,1,2}…{9,10,11}; after 2 priming cycles in_rdy stays 1 every cycle.
- LAST_EN, IN=3, OUT=2: 3 words, the last with in_last=1 (9 coefs) → 5th output {8,0}, keep=2'b01, last=1; in_rdy=0 until that pop.
- LAST_EN, IN=3, OUT=2: 2 words with in_last → 3 outputs, the 3rd has keep=2'b11 and last=1; no extra word.
- Random out_rdy backpressure, IN=5, OUT=8, 1000 words → scoreboard shows exact order, and out_data is stable while out_vld & ~out_rdy.
- Assert s_rst_n=0 for 1 cycle with occ=4 → next cycle occ=0, out_vld=0, in_rdy=1; the next packet is output uncorrupted.
